// File: rtl/pixie_pkg.sv
// pixie_pkg: shared constants and types for the Pixie (CDP1861) display back end.
//   - Frame-buffer geometry (1024 x 8, 8 bytes per source line, 128 source lines).
//   - Raster timing of the 342 x 262 output frame and its 256 x 256 active window.
//   - rgb_t colour type, the lit-pixel colour and a half-intensity helper
//     (the helper is used only when PIXIE_SCANLINE_EN is defined).
package pixie_pkg;

    localparam int PIXIE_FB_DEPTH       = 1024;
    localparam int PIXIE_FB_AW          = 10;
    localparam int PIXIE_BYTES_PER_LINE = 8;
    localparam int PIXIE_LINES          = 128;

    // Raster counters are 9 bits wide: 0..341 horizontally, 0..261 vertically.
    localparam int CNT_W    = 9;
    localparam int H_ACTIVE = 256;
    localparam int H_TOTAL  = 342;
    localparam int HS_START = 272;
    localparam int HS_END   = 297;
    localparam int V_ACTIVE = 256;
    localparam int V_TOTAL  = 262;
    localparam int VS_START = 258;
    localparam int VS_END   = 261;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam rgb_t FG_RGB = '{r: 8'hFF, g: 8'hFF, b: 8'hFF};

    // Each component shifted right by one: the dimmed colour of odd scanlines.
    function automatic rgb_t halve(input rgb_t c);
        rgb_t o;
        o.r = {1'b0, c.r[7:1]};
        o.g = {1'b0, c.g[7:1]};
        o.b = {1'b0, c.b[7:1]};
        return o;
    endfunction

endpackage

// File: rtl/pixie_fb_ram.sv
// pixie_fb_ram: simple dual-port 1024 x 8 frame buffer.
//   clk      in   system clock
//   we       in   write strobe
//   wr_addr  in   write address (10 bits)
//   wr_data  in   write data
//   re       in   read enable (the pixel clock enable)
//   rd_addr  in   read address (10 bits)
//   rd_data  out  registered read data
// A read and a write to the same address in the same clock return the byte
// held before the write (read-first), because both use non-blocking updates.
module pixie_fb_ram
    import pixie_pkg::*;
(
    input  logic                   clk,
    input  logic                   we,
    input  logic [PIXIE_FB_AW-1:0] wr_addr,
    input  logic [7:0]             wr_data,
    input  logic                   re,
    input  logic [PIXIE_FB_AW-1:0] rd_addr,
    output logic [7:0]             rd_data
);

    logic [7:0] mem [PIXIE_FB_DEPTH];

    // Storage write and read-first registered read port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
        if (re) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/pixie_dp_back_end.sv
// pixie_dp_back_end: display back end of the Pixie (CDP1861) path.
// Scans the 64 x 128 frame buffer out as a 256 x 256 bitmap (each bit 4 pixels
// wide, each source line shown twice) inside a 342 x 262 raster.
//   clk          in   system clock
//   reset_n      in   asynchronous active-low reset
//   ce_pix       in   pixel clock enable; the raster advances only when 1
//   mem_wr_en    in   frame-buffer write strobe (independent of ce_pix)
//   mem_addr     in   frame-buffer write address (10 bits)
//   mem_data     in   write data, bit 7 = leftmost pixel
//   video_r/g/b  out  pixel colour, 8 bits each
//   hsync        out  active-high horizontal sync
//   vsync        out  active-high vertical sync
//   hblank       out  1 outside the 256 active pixels
//   vblank       out  1 outside the 256 active lines
//   frame_start  out  one-clock pulse when the raster wraps to (0,0)
// Optional feature macro PIXIE_SCANLINE_EN: lit pixels on odd output lines
// are shown at half intensity. Default build: both lines of a pair identical.
module pixie_dp_back_end
    import pixie_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   ce_pix,
    input  logic                   mem_wr_en,
    input  logic [PIXIE_FB_AW-1:0] mem_addr,
    input  logic [7:0]             mem_data,
    output logic [7:0]             video_r,
    output logic [7:0]             video_g,
    output logic [7:0]             video_b,
    output logic                   hsync,
    output logic                   vsync,
    output logic                   hblank,
    output logic                   vblank,
    output logic                   frame_start
);

    logic [CNT_W-1:0]       h_cnt;
    logic [CNT_W-1:0]       v_cnt;
    logic                   h_wrap;
    logic                   v_wrap;
    logic [PIXIE_FB_AW-1:0] rd_addr;
    logic [7:0]             fb_q;
    logic                   hs_raw;
    logic                   vs_raw;
    logic                   hb_raw;
    logic                   vb_raw;
    logic [2:0]             bit_sel1;
    logic                   hs1;
    logic                   vs1;
    logic                   hb1;
    logic                   vb1;
    rgb_t                   pix_rgb;

    assign h_wrap = (h_cnt == CNT_W'(H_TOTAL - 1));
    assign v_wrap = (v_cnt == CNT_W'(V_TOTAL - 1));

    // 8 bytes per source line; dropping v_cnt[0] repeats each source line twice.
    assign rd_addr = {v_cnt[7:1], h_cnt[7:5]};

    assign hs_raw = (h_cnt >= CNT_W'(HS_START)) && (h_cnt < CNT_W'(HS_END));
    assign vs_raw = (v_cnt >= CNT_W'(VS_START)) && (v_cnt < CNT_W'(VS_END));
    assign hb_raw = (h_cnt >= CNT_W'(H_ACTIVE));
    assign vb_raw = (v_cnt >= CNT_W'(V_ACTIVE));

    // Raster position: h wraps every line, v steps on each h wrap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (ce_pix) begin
            if (h_wrap) begin
                h_cnt <= '0;
                v_cnt <= v_wrap ? '0 : v_cnt + CNT_W'(1);
            end else begin
                h_cnt <= h_cnt + CNT_W'(1);
            end
        end
    end

    // Pulse marks the enable on which both counters return to (0,0).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_start <= 1'b0;
        end else begin
            frame_start <= ce_pix & h_wrap & v_wrap;
        end
    end

    pixie_fb_ram u_fb_ram (
        .clk     (clk),
        .we      (mem_wr_en),
        .wr_addr (mem_addr),
        .wr_data (mem_data),
        .re      (ce_pix),
        .rd_addr (rd_addr),
        .rd_data (fb_q)
    );

    // Stage 1: travels alongside the RAM read. Blanks reset to 1 so the first
    // pixel leaving the pipe after reset is blank rather than stale data.
    // Bit index 7 - h[4:2] is the inverted field, keeping bit 7 on the left.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_sel1 <= '0;
            hs1      <= 1'b0;
            vs1      <= 1'b0;
            hb1      <= 1'b1;
            vb1      <= 1'b1;
        end else if (ce_pix) begin
            bit_sel1 <= ~h_cnt[4:2];
            hs1      <= hs_raw;
            vs1      <= vs_raw;
            hb1      <= hb_raw;
            vb1      <= vb_raw;
        end
    end

`ifdef PIXIE_SCANLINE_EN
    logic odd1;

    // Line parity delayed with the pixel so dimming lands on the right line.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            odd1 <= 1'b0;
        end else if (ce_pix) begin
            odd1 <= v_cnt[0];
        end
    end
`endif

    // Colour of the pixel in stage 1; anything blanked is black.
    always_comb begin
        pix_rgb = '0;
        if (!hb1 && !vb1 && fb_q[bit_sel1]) begin
`ifdef PIXIE_SCANLINE_EN
            pix_rgb = odd1 ? halve(FG_RGB) : FG_RGB;
`else
            pix_rgb = FG_RGB;
`endif
        end
    end

    // Stage 2: registered outputs to the video mixer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            video_r <= '0;
            video_g <= '0;
            video_b <= '0;
            hsync   <= 1'b0;
            vsync   <= 1'b0;
            hblank  <= 1'b1;
            vblank  <= 1'b1;
        end else if (ce_pix) begin
            video_r <= pix_rgb.r;
            video_g <= pix_rgb.g;
            video_b <= pix_rgb.b;
            hsync   <= hs1;
            vsync   <= vs1;
            hblank  <= hb1;
            vblank  <= vb1;
        end
    end

endmodule

// File: tb/tb_pixie_dp_back_end.sv
// tb_pixie_dp_back_end: self-checking bench for pixie_dp_back_end.
// Expected pixels are pushed to a queue when the raster position is driven
// and popped when the pipeline delivers them two pixel enables later.
module tb_pixie_dp_back_end;

    localparam int HT = 342;
    localparam int VT = 262;

    typedef struct packed {
        int         h;
        int         v;
        logic [23:0] rgb;
        logic       hs;
        logic       vs;
        logic       hb;
        logic       vb;
    } exp_t;

    logic       clk;
    logic       reset_n;
    logic       ce_pix;
    logic       mem_wr_en;
    logic [9:0] mem_addr;
    logic [7:0] mem_data;
    logic [7:0] video_r;
    logic [7:0] video_g;
    logic [7:0] video_b;
    logic       hsync;
    logic       vsync;
    logic       hblank;
    logic       vblank;
    logic       frame_start;

    exp_t       sb_q[$];
    exp_t       cur_exp;
    exp_t       blank_exp;
    logic       exp_fs;
    logic [7:0] model_ram [1024];
    int         mh;
    int         mv;
    int         compared;
    int         mismatched;

    pixie_dp_back_end dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .ce_pix      (ce_pix),
        .mem_wr_en   (mem_wr_en),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .video_r     (video_r),
        .video_g     (video_g),
        .video_b     (video_b),
        .hsync       (hsync),
        .vsync       (vsync),
        .hblank      (hblank),
        .vblank      (vblank),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected output for raster position (h,v), using the frame buffer as it
    // stands before any write in the same clock.
    function automatic exp_t make_exp(input int h, input int v);
        exp_t       e;
        logic [7:0] b;
        int         bi;
        logic       lit;
        e.h  = h;
        e.v  = v;
        e.hb = (h >= 256);
        e.vb = (v >= 256);
        e.hs = (h >= 272) && (h < 297);
        e.vs = (v >= 258) && (v < 261);
        lit  = 1'b0;
        if (!e.hb && !e.vb) begin
            b   = model_ram[(v / 2) * 8 + (h / 32)];
            bi  = 7 - ((h % 32) / 4);
            lit = b[bi];
        end
        e.rgb = lit ? 24'hFFFFFF : 24'h000000;
`ifdef PIXIE_SCANLINE_EN
        if (lit && (v % 2 == 1)) e.rgb = 24'h7F7F7F;
`endif
        return e;
    endfunction

    // Drive one clock of inputs and advance the reference raster.
    task automatic applyStimulus(input logic ce, input logic we,
                                 input logic [9:0] a, input logic [7:0] d);
        ce_pix    = ce;
        mem_wr_en = we;
        mem_addr  = a;
        mem_data  = d;
        @(posedge clk);
        #1;
        exp_fs = 1'b0;
        if (reset_n && ce) begin
            sb_q.push_back(make_exp(mh, mv));
            if (mh == HT - 1 && mv == VT - 1) exp_fs = 1'b1;
            if (mh == HT - 1) begin
                mh = 0;
                mv = (mv == VT - 1) ? 0 : mv + 1;
            end else begin
                mh = mh + 1;
            end
            if (sb_q.size() > 0) cur_exp = sb_q.pop_front();
        end
        if (we) model_ram[a] = d;
    endtask

    task automatic restart_model();
        mh = 0;
        mv = 0;
        sb_q.delete();
        sb_q.push_back(blank_exp);
        cur_exp = blank_exp;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b0, 10'd0, 8'd0);
            compared++;
            if ({video_r, video_g, video_b, hsync, vsync, hblank, vblank, frame_start}
                !== {24'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0}) begin
                mismatched++;
                $display("[TB] FAIL reset_outputs cyc=%0d: got rgb=%h hs=%b vs=%b hb=%b vb=%b fs=%b, expected rgb=000000 hs=0 vs=0 hb=1 vb=1 fs=0",
                         i, {video_r, video_g, video_b}, hsync, vsync, hblank, vblank, frame_start);
            end
            compared++;
            if ({dut.h_cnt, dut.v_cnt} !== 18'd0) begin
                mismatched++;
                $display("[TB] FAIL reset_counters cyc=%0d: got h=%0d v=%0d, expected 0 0",
                         i, dut.h_cnt, dut.v_cnt);
            end
        end
    endtask

    // Fill the frame buffer while reset is held; RAM writes ignore reset.
    task automatic test_preload();
        logic [7:0] d;
        for (int a = 0; a < 1024; a++) begin
            d = 8'h00;
            if (a == 0)    d = 8'h80;
            if (a == 9)    d = 8'h3C;
            if (a == 17)   d = 8'hC3;
            if (a == 300)  d = 8'h5A;
            if (a == 1023) d = 8'hA5;
            applyStimulus(1'b0, 1'b1, 10'(a), d);
        end
        compared++;
        if ({video_r, video_g, video_b, hblank, vblank} !== {24'h0, 1'b1, 1'b1}) begin
            mismatched++;
            $display("[TB] FAIL preload_outputs: got rgb=%h hb=%b vb=%b, expected rgb=000000 hb=1 vb=1",
                     {video_r, video_g, video_b}, hblank, vblank);
        end
    endtask

    task automatic test_frame();
        int   ce_count;
        int   guard;
        int   hs_total;
        int   vs_total;
        bit   fs_seen;
        bit   wrote;
        bit   hs_first;
        bit   vs_first;
        logic prev_hs;
        logic prev_vs;
        logic we;
        ce_count = 0;
        guard    = 0;
        hs_total = 0;
        vs_total = 0;
        fs_seen  = 0;
        wrote    = 0;
        hs_first = 0;
        vs_first = 0;
        prev_hs  = 1'b0;
        prev_vs  = 1'b0;
        reset_n  = 1'b1;
        restart_model();
        // Alternate idle and active enables: idle clocks must hold every output.
        for (int i = 0; i < 20; i++) begin
            applyStimulus(logic'(i % 2), 1'b0, 10'd0, 8'd0);
            if (i % 2 == 1) ce_count++;
            compared++;
            if ({video_r, video_g, video_b, hsync, vsync, hblank, vblank}
                !== {cur_exp.rgb, cur_exp.hs, cur_exp.vs, cur_exp.hb, cur_exp.vb}) begin
                mismatched++;
                $display("[TB] FAIL ce_hold i=%0d h=%0d v=%0d: got rgb=%h hs=%b vs=%b hb=%b vb=%b, expected rgb=%h hs=%b vs=%b hb=%b vb=%b",
                         i, cur_exp.h, cur_exp.v, {video_r, video_g, video_b}, hsync, vsync, hblank, vblank,
                         cur_exp.rgb, cur_exp.hs, cur_exp.vs, cur_exp.hb, cur_exp.vb);
            end
        end
        while (!fs_seen && guard < 95000 && mismatched < 100) begin
            guard++;
            // Write addr 8 on the very clock that reads it for pixel (0,2).
            we = (mh == 0 && mv == 2 && !wrote);
            if (we) wrote = 1;
            applyStimulus(1'b1, we, 10'd8, 8'hFF);
            ce_count++;
            compared++;
            if ({video_r, video_g, video_b, hsync, vsync, hblank, vblank}
                !== {cur_exp.rgb, cur_exp.hs, cur_exp.vs, cur_exp.hb, cur_exp.vb}) begin
                mismatched++;
                $display("[TB] FAIL pixel h=%0d v=%0d: got rgb=%h hs=%b vs=%b hb=%b vb=%b, expected rgb=%h hs=%b vs=%b hb=%b vb=%b",
                         cur_exp.h, cur_exp.v, {video_r, video_g, video_b}, hsync, vsync, hblank, vblank,
                         cur_exp.rgb, cur_exp.hs, cur_exp.vs, cur_exp.hb, cur_exp.vb);
            end
            compared++;
            if (frame_start !== exp_fs) begin
                mismatched++;
                $display("[TB] FAIL frame_start ce=%0d: got %b, expected %b", ce_count, frame_start, exp_fs);
            end
            if (cur_exp.v == 2 && cur_exp.h <= 1) begin
                compared++;
                if ({video_r, video_g, video_b} !== ((cur_exp.h == 0) ? 24'h000000 : 24'hFFFFFF)) begin
                    mismatched++;
                    $display("[TB] FAIL read_first h=%0d v=2: got rgb=%h, expected %h", cur_exp.h,
                             {video_r, video_g, video_b}, (cur_exp.h == 0) ? 24'h000000 : 24'hFFFFFF);
                end
            end
            if (hsync === 1'b1) hs_total++;
            if (vsync === 1'b1) vs_total++;
            if (hsync === 1'b1 && prev_hs === 1'b0 && !hs_first) begin
                hs_first = 1;
                compared++;
                if (cur_exp.h != 272) begin
                    mismatched++;
                    $display("[TB] FAIL hsync_start: got h=%0d, expected 272", cur_exp.h);
                end
            end
            if (vsync === 1'b1 && prev_vs === 1'b0 && !vs_first) begin
                vs_first = 1;
                compared++;
                if (cur_exp.v != 258 || cur_exp.h != 0) begin
                    mismatched++;
                    $display("[TB] FAIL vsync_start: got h=%0d v=%0d, expected h=0 v=258", cur_exp.h, cur_exp.v);
                end
            end
            prev_hs = hsync;
            prev_vs = vsync;
            if (frame_start === 1'b1) fs_seen = 1;
        end
        compared++;
        if (!fs_seen) begin
            mismatched++;
            $display("[TB] FAIL frame_start_timeout: got no pulse after %0d enables, expected one at 89604", ce_count);
        end else if (ce_count != 89604) begin
            mismatched++;
            $display("[TB] FAIL frame_period: got %0d enables, expected 89604", ce_count);
        end
        compared++;
        if (hs_total != 25 * 262) begin
            mismatched++;
            $display("[TB] FAIL hsync_width: got %0d active pixels, expected %0d", hs_total, 25 * 262);
        end
        compared++;
        if (vs_total != 3 * 342) begin
            mismatched++;
            $display("[TB] FAIL vsync_width: got %0d active pixels, expected %0d", vs_total, 3 * 342);
        end
    endtask

    task automatic test_midframe_reset();
        for (int i = 0; i < 700; i++) begin
            applyStimulus(1'b1, 1'b0, 10'd0, 8'd0);
            compared++;
            if ({video_r, video_g, video_b, hsync, vsync, hblank, vblank, frame_start}
                !== {cur_exp.rgb, cur_exp.hs, cur_exp.vs, cur_exp.hb, cur_exp.vb, exp_fs}) begin
                mismatched++;
                $display("[TB] FAIL frame2_pixel h=%0d v=%0d: got rgb=%h hs=%b vs=%b hb=%b vb=%b fs=%b, expected rgb=%h",
                         cur_exp.h, cur_exp.v, {video_r, video_g, video_b}, hsync, vsync, hblank, vblank,
                         frame_start, cur_exp.rgb);
            end
        end
        // Asynchronous assertion: outputs must clear without a clock edge.
        reset_n = 1'b0;
        #1;
        compared++;
        if ({video_r, video_g, video_b, hsync, vsync, hblank, vblank, frame_start}
            !== {24'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0}) begin
            mismatched++;
            $display("[TB] FAIL async_reset: got rgb=%h hs=%b vs=%b hb=%b vb=%b fs=%b, expected rgb=000000 hs=0 vs=0 hb=1 vb=1 fs=0",
                     {video_r, video_g, video_b}, hsync, vsync, hblank, vblank, frame_start);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        restart_model();
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'b1, 1'b0, 10'd0, 8'd0);
            compared++;
            if ({video_r, video_g, video_b, hsync, vsync, hblank, vblank}
                !== {cur_exp.rgb, cur_exp.hs, cur_exp.vs, cur_exp.hb, cur_exp.vb}) begin
                mismatched++;
                $display("[TB] FAIL restart_pixel i=%0d h=%0d v=%0d: got rgb=%h hb=%b vb=%b, expected rgb=%h hb=%b vb=%b",
                         i, cur_exp.h, cur_exp.v, {video_r, video_g, video_b}, hblank, vblank,
                         cur_exp.rgb, cur_exp.hb, cur_exp.vb);
            end
            if (i < 2) begin
                compared++;
                if ({hblank, video_r} !== ((i == 0) ? {1'b1, 8'h00} : {1'b0, 8'hFF})) begin
                    mismatched++;
                    $display("[TB] FAIL restart_first_pixels i=%0d: got hb=%b r=%h, expected %s",
                             i, hblank, video_r, (i == 0) ? "hb=1 r=00" : "hb=0 r=ff");
                end
            end
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        reset_n    = 1'b0;
        ce_pix     = 1'b0;
        mem_wr_en  = 1'b0;
        mem_addr   = '0;
        mem_data   = '0;
        exp_fs     = 1'b0;
        mh         = 0;
        mv         = 0;
        blank_exp  = '{h: -1, v: -1, rgb: 24'h0, hs: 1'b0, vs: 1'b0, hb: 1'b1, vb: 1'b1};
        cur_exp    = blank_exp;
        for (int a = 0; a < 1024; a++) model_ram[a] = 8'h00;
        $display("[TB] starting pixie_dp_back_end bench");
        test_reset();
        test_preload();
        test_frame();
        test_midframe_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
